// File: rtl/thermo_pkg.sv
// Shared types and constants for the thermostat request generator.
package thermo_pkg;

  localparam int unsigned TEMP_W_DEF = 12;
  localparam int unsigned FRAC_BITS  = 4;

  localparam logic MODE_HEAT = 1'b0;
  localparam logic MODE_COOL = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEAT    = 2'd1,
    COOL    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  typedef struct packed {
    logic a;
    logic b;
    logic lockout;
    logic fault;
  } req_t;

endpackage

// File: rtl/thermostat_ctrl_if.sv
// Sensor inputs and unit request outputs of the thermostat controller.
interface thermostat_ctrl_if
  import thermo_pkg::*;
#(
  parameter int unsigned TEMP_W = TEMP_W_DEF
) ();

  logic signed [TEMP_W-1:0] target;
  logic signed [TEMP_W-1:0] ambient;
  logic                     temp_valid;
  logic                     status;
  logic                     A;
  logic                     B;
  logic                     lockout;
  logic                     tick;
  logic                     fault;

  modport master (
    output target, ambient, temp_valid, status,
    input  A, B, lockout, tick, fault
  );

  modport slave (
    input  target, ambient, temp_valid, status,
    output A, B, lockout, tick, fault
  );

endinterface

// File: rtl/thermo_tick_gen.sv
// Sample-tick prescaler: registered one-cycle pulse while the count sits at SAMPLE_DIV-1.
module thermo_tick_gen
  import thermo_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 5
) (
  input  logic clock,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0] count;

  // tick is loaded one cycle early so it lines up with count == SAMPLE_DIV-1
  always_ff @(posedge clock) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      if (count == CNT_W'(SAMPLE_DIV - 1)) count <= '0;
      else                                 count <= count + CNT_W'(1);
      tick <= (count == CNT_W'(SAMPLE_DIV - 2));
    end
  end

endmodule

// File: rtl/thermostat_ctrl.sv
// Heat/cool request generator with hysteresis and compressor run/idle protection.
// Optional stale-sensor guard enabled by defining THERMO_STALE_GUARD_EN.
module thermostat_ctrl
  import thermo_pkg::*;
#(
  parameter int unsigned TEMP_W     = TEMP_W_DEF,
  parameter int unsigned THRESH     = 32,
  parameter int unsigned SAMPLE_DIV = 5,
  parameter int unsigned MIN_RUN    = 4,
  parameter int unsigned MIN_IDLE   = 2
`ifdef THERMO_STALE_GUARD_EN
  ,
  parameter int unsigned STALE_TICKS = 8
`endif
) (
  input logic              clock,
  input logic              rst,
  thermostat_ctrl_if.slave bus
);

  localparam int unsigned EXT_W  = TEMP_W + 2;
  localparam int unsigned RUN_W  = $clog2(MIN_RUN + 1);
  localparam int unsigned IDLE_W = $clog2(MIN_IDLE + 1);
`ifdef THERMO_STALE_GUARD_EN
  localparam int unsigned STALE_W = $clog2(STALE_TICKS + 1);
`endif

  logic tick;

  thermo_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick_gen (
    .clock (clock),
    .rst   (rst),
    .tick  (tick)
  );

  // Two guard bits keep ambient+THRESH exact at the range extremes
  logic signed [EXT_W-1:0] t_x, a_x, th_x;
  logic on_heat, off_heat, on_cool, off_cool;

  assign t_x  = {{2{bus.target[TEMP_W-1]}}, bus.target};
  assign a_x  = {{2{bus.ambient[TEMP_W-1]}}, bus.ambient};
  assign th_x = EXT_W'(THRESH);

  assign on_heat  = (t_x >= a_x + th_x);
  assign off_heat = (t_x <= a_x);
  assign on_cool  = (t_x + th_x <= a_x);
  assign off_cool = (t_x >= a_x);

  state_t            state, state_next;
  logic [RUN_W-1:0]  run_cnt, run_next, run_inc;
  logic [IDLE_W-1:0] idle_cnt, idle_next, idle_inc;
  req_t              out_q, out_next;
`ifdef THERMO_STALE_GUARD_EN
  logic [STALE_W-1:0] stale_cnt, stale_next;
`endif

  assign run_inc  = (run_cnt == RUN_W'(MIN_RUN))    ? run_cnt  : run_cnt + RUN_W'(1);
  assign idle_inc = (idle_cnt == IDLE_W'(MIN_IDLE)) ? idle_cnt : idle_cnt + IDLE_W'(1);

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= IDLE;
      run_cnt  <= '0;
      idle_cnt <= '0;
      out_q    <= '0;
`ifdef THERMO_STALE_GUARD_EN
      stale_cnt <= '0;
`endif
    end else begin
      state    <= state_next;
      run_cnt  <= run_next;
      idle_cnt <= idle_next;
      out_q    <= out_next;
`ifdef THERMO_STALE_GUARD_EN
      stale_cnt <= stale_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    run_next   = run_cnt;
    idle_next  = idle_cnt;
`ifdef THERMO_STALE_GUARD_EN
    stale_next = stale_cnt;
`endif
    if (tick) begin
`ifdef THERMO_STALE_GUARD_EN
      if (bus.temp_valid)                         stale_next = '0;
      else if (stale_cnt != STALE_W'(STALE_TICKS)) stale_next = stale_cnt + STALE_W'(1);
`endif
      case (state)
        IDLE: begin
          if (bus.temp_valid) begin
            if (bus.status == MODE_HEAT && on_heat) begin
              state_next = HEAT;
              run_next   = '0;
            end else if (bus.status == MODE_COOL && on_cool) begin
              state_next = COOL;
              run_next   = '0;
            end
          end
        end
        HEAT, COOL: begin
          // A mode flip while running ends the run at once, valid sample or not
          if (bus.status != ((state == COOL) ? MODE_COOL : MODE_HEAT)) begin
            state_next = HOLDOFF;
            idle_next  = '0;
          end else if (bus.temp_valid) begin
            run_next = run_inc;
            if (((state == HEAT) ? off_heat : off_cool) && run_inc == RUN_W'(MIN_RUN)) begin
              state_next = HOLDOFF;
              idle_next  = '0;
            end
          end
        end
        HOLDOFF: begin
          if (bus.temp_valid) begin
            if (idle_inc == IDLE_W'(MIN_IDLE)) state_next = IDLE;
            else                               idle_next  = idle_inc;
          end
        end
        default: state_next = IDLE;
      endcase
`ifdef THERMO_STALE_GUARD_EN
      if (stale_next == STALE_W'(STALE_TICKS)) begin
        state_next = HOLDOFF;
        idle_next  = '0;
      end
`endif
    end
  end

  always_comb begin
    out_next         = '0;
    out_next.a       = (state_next == HEAT);
    out_next.b       = (state_next == COOL);
    out_next.lockout = (state_next == HOLDOFF);
`ifdef THERMO_STALE_GUARD_EN
    out_next.fault   = (stale_next == STALE_W'(STALE_TICKS));
`endif
  end

  assign bus.A       = out_q.a;
  assign bus.B       = out_q.b;
  assign bus.lockout = out_q.lockout;
  assign bus.fault   = out_q.fault;
  assign bus.tick    = tick;

endmodule
